// File: rtl/pipe_pkg.sv
// Shared entry type and helpers for the pipeline stage register.
// Entry fields are sized for the widest legal configuration; unused high bits stay zero.
package pipe_pkg;

    localparam int DATA_W_MAX = 256;
    localparam int RD_W_MAX   = 8;

    localparam logic [RD_W_MAX-1:0] RD_ZERO = '0;

    typedef struct packed {
        logic [DATA_W_MAX-1:0] data;
        logic [RD_W_MAX-1:0]   rd;
        logic                  regwrite;
        logic                  valid;
    } pipe_entry_t;

    // Register 0 is hard-wired, so a pending write to it is never a hazard.
    function automatic logic entry_writes(input pipe_entry_t e, input logic [RD_W_MAX-1:0] rd);
        return e.valid && e.regwrite && (e.rd == rd) && (rd != RD_ZERO);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry register: load a new entry, or clear its valid bit.
// Clearing keeps the payload so the stage outputs hold their last value.
module pipe_entry_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clr,
    input  pipe_entry_t d,
    output pipe_entry_t q
);

    // NOTE: non-blocking assignments in always_ff so every register samples pre-edge values.
    // NOTE: the payload is reset too, not just valid, because the stage must present zero data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with hazard query and occupancy count.
// Define PIPE_SKID_EN for a two-entry (main + skid) build with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_regwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite,
    output logic [1:0]        occupancy,
    input  logic [RD_W-1:0]   hz_rd,
    output logic              hz_hit
);

    pipe_entry_t         in_entry;
    pipe_entry_t         main_d;
    pipe_entry_t         main_q;
    logic                main_load;
    logic                main_clr;
    logic                in_xfer;
    logic                out_xfer;
    logic [RD_W_MAX-1:0] hz_rd_ext;
    logic [1:0]          occ_q;

    always_comb begin
        in_entry          = '0;
        in_entry.data     = DATA_W_MAX'(in_data);
        in_entry.rd       = RD_W_MAX'(in_rd);
        in_entry.regwrite = in_regwrite;
        in_entry.valid    = 1'b1;
    end

    assign hz_rd_ext = RD_W_MAX'(hz_rd);
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = main_q.valid && out_ready;

`ifdef PIPE_SKID_EN
    pipe_entry_t skid_q;
    logic        skid_load;
    logic        skid_clr;

    // Skid is only ever occupied while main is, so "skid empty" alone gates acceptance.
    assign in_ready = !skid_q.valid;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        main_d    = skid_q.valid ? skid_q : in_entry;
        main_load = (out_xfer && skid_q.valid) || (in_xfer && (!main_q.valid || out_xfer));
        main_clr  = flush || (out_xfer && !skid_q.valid && !in_xfer);
        skid_load = in_xfer && main_q.valid && !out_xfer;
        skid_clr  = flush || (out_xfer && skid_q.valid);
    end

    pipe_entry_reg u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clr   (skid_clr),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign hz_hit = entry_writes(main_q, hz_rd_ext) || entry_writes(skid_q, hz_rd_ext);
`else
    assign in_ready = !main_q.valid || out_ready;

    always_comb begin
        main_d    = in_entry;
        main_load = in_xfer;
        main_clr  = flush || (out_xfer && !in_xfer);
    end

    assign hz_hit = entry_writes(main_q, hz_rd_ext);
`endif

    pipe_entry_reg u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clr   (main_clr),
        .d     (main_d),
        .q     (main_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occupancy    = occ_q;
    assign out_valid    = main_q.valid;
    assign out_regwrite = main_q.valid && main_q.regwrite;
    assign out_data     = main_q.data[DATA_W-1:0];
    assign out_rd       = main_q.rd[RD_W-1:0];

    // High payload bits are always zero-filled and never leave the stage.
    if (DATA_W < DATA_W_MAX) begin : g_data_pad
        logic unused_data_hi;
        assign unused_data_hi = ^main_q.data[DATA_W_MAX-1:DATA_W];
    end

endmodule
